apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
Converts a simple valid/ready command/response interface into APB3 SETUP/ACCESS transfers. It is the upstream stage that drives the master side of the APB demux, which routes the transfer to one of the slaves.
Only one transfer is outstanding at a time. Responses return PRDATA/PSLVERR to the requester.

Parameters:
ADDR_WIDTH, 32, width of cmd_addr/PADDR
DATA_WIDTH, 32, width of wdata/rdata buses (multiple of 8)
TIMEOUT_CYCLES, 256, ACCESS-phase cycle limit; used only with APB_TIMEOUT_EN

Ports:
PCLK  in  1  clock, all logic on rising edge
PRESET  in  1  synchronous active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  bridge accepts command
cmd_addr  in  ADDR_WIDTH  byte address
cmd_write  in  1  1=write, 0=read
cmd_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  response available
rsp_ready  in  1  requester takes response
rsp_rdata  out  DATA_WIDTH  read data (0 for writes/errors)
rsp_slverr  out  1  error response
rsp_timeout  out  1  response caused by timeout (tied 0 without macro)
PSEL  out  1  APB select to demux
PENABLE  out  1  APB enable
PADDR  out  ADDR_WIDTH  APB address
PWRITE  out  1  APB direction
PWDATA  out  DATA_WIDTH  APB write data
PREADY  in  1  muxed slave ready
PRDATA  in  DATA_WIDTH  muxed slave read data
PSLVERR  in  1  muxed slave error

Behaviour:
- Reset (PRESET=1 at edge): state=IDLE; PSEL, PENABLE, PWRITE, rsp_valid, rsp_slverr, rsp_timeout=0; PADDR, PWDATA, rsp_rdata=0. Reset mid-transfer drops PSEL/PENABLE at that edge; the pending response is discarded.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1; all other states 0. On cmd_valid&cmd_ready, register addr/write/wdata.
  - If cmd_addr[1:0]!=0 (misaligned): go to RESP with slverr=1, rdata=0; no APB transfer is issued.
  - Otherwise go to SETUP.
- SETUP (1 cycle): PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA from registered command; next ACCESS.
- ACCESS: PSEL=1, PENABLE=1, address/control/data held stable. When PREADY=1:
  - capture rsp_slverr=PSLVERR;
  - rsp_rdata=PRDATA if read and PSLVERR=0, else 0;
  - next RESP, PSEL/PENABLE=0 in RESP.
  - If PREADY=0, remain in ACCESS indefinitely (without macro).
- RESP: rsp_valid=1, response outputs stable until rsp_valid&rsp_ready; then IDLE.
- No back-to-back overlap: the next command is accepted no earlier than the cycle after the response handshake.
- Latency: accept at cycle N, SETUP N+1, ACCESS N+2. With zero-wait PREADY, rsp_valid is asserted at N+3. Each PREADY wait state adds 1.
- PADDR/PWDATA hold their last value in IDLE/RESP; the demux decodes only while PSEL=1.
- rsp_ready asserted while rsp_valid=0 is ignored.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined: a counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0. When the count reaches TIMEOUT_CYCLES-1 with PREADY still 0:
  - PSEL/PENABLE deassert at the next edge;
  - go to RESP with rsp_slverr=1, rsp_timeout=1, rsp_rdata=0.
  - PREADY=1 on the same cycle as expiry wins: normal completion, rsp_timeout=0.
  - Counter width is $clog2(TIMEOUT_CYCLES)+1.
- Not defined: no counter is instantiated; rsp_timeout is constant 0; ACCESS waits forever.

Decomposition:
- Shared package apb_pkg:
  - apb_state_e enum {IDLE, SETUP, ACCESS, RESP};
  - apb_rsp_t struct {rdata, slverr, timeout};
  - constant APB_ALIGN_BITS=2.
- Sub-module apb_timeout_counter (clear, enable, expired output), instantiated only under APB_TIMEOUT_EN.
- FSM and datapath registers stay in apb_master_bridge.

Test Plan:
- Write 0x0000_0040 / 0xDEAD_BEEF, PREADY=1 immediately -> SETUP cycle then ACCESS cycle with PWRITE=1, PWDATA=0xDEADBEEF; rsp_valid at accept+3, slverr=0, rdata=0.
- Read 0x0000_0084, PREADY low 3 ACCESS cycles then 1 with PRDATA=0x1234_5678 -> PADDR stable all 4 ACCESS cycles; rsp_rdata=0x12345678 at accept+6.
- Read with PSLVERR=1, PRDATA=0xFFFF_FFFF -> rsp_slverr=1, rsp_rdata=0; rsp_ready held low 5 cycles -> response stable, cmd_ready=0 throughout.
- Misaligned cmd_addr=0x0000_0003 -> PSEL never asserts; rsp_valid next cycle with slverr=1.
- PRESET pulsed during ACCESS -> PSEL/PENABLE=0 at the following edge, rsp_valid=0, cmd_ready=1 after reset release.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=8, PREADY held 0 -> exactly 8 ACCESS cycles, then rsp_slverr=1, rsp_timeout=1. Repeat with PREADY=1 on the 8th cycle -> normal response, rsp_timeout=0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types for the APB master bridge: FSM state encoding, response bundle, alignment constant.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apb_pkg;

  // Transfers must be word aligned: the low APB_ALIGN_BITS address bits must be zero.
  localparam int APB_ALIGN_BITS = 2;

  // Width of the read data carried in the response bundle; the bridge DATA_WIDTH must match.
  localparam int APB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic [APB_DATA_WIDTH-1:0] rdata;
    logic                      slverr;
    logic                      timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_timeout_counter.sv
// ACCESS-phase wait counter: clears on clr_i, counts cycles with en_i, flags LIMIT-1 reached.
// Latency: expired_o is combinational from the registered count.
// Backpressure: none; the count holds once expired until cleared.
// Ports: clk_i/rst_i clock and sync active-high reset, clr_i zero the count,
//        en_i count one wait cycle, expired_o count == LIMIT-1.
module apb_timeout_counter #(
  parameter int LIMIT = 256,
  localparam int CW   = $clog2(LIMIT) + 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired_o = (cnt_q == CW'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready command to APB3 SETUP/ACCESS bridge, one transfer outstanding at a time.
// Latency: accept at N, SETUP N+1, ACCESS N+2, rsp_valid N+3 plus one per PREADY wait state.
// Backpressure: cmd_ready only in IDLE; the response is held until rsp_ready, PREADY stalls ACCESS.
// Ports: PCLK/PRESET clock and sync active-high reset; cmd_* request channel; rsp_* response
//        channel; PSEL/PENABLE/PADDR/PWRITE/PWDATA master side, PREADY/PRDATA/PSLVERR muxed slave.
// Optional: define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait cycles.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR
);

  apb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  apb_rsp_t              rsp_q, rsp_d;
  logic                  to_expired;

`ifdef APB_TIMEOUT_EN
  // Count restarts while in SETUP so the first ACCESS cycle sees zero.
  apb_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (PCLK),
    .rst_i     (PRESET),
    .clr_i     (state_q == SETUP),
    .en_i      ((state_q == ACCESS) && !PREADY),
    .expired_o (to_expired)
  );
`else
  assign to_expired = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      rsp_q   <= rsp_d;
    end
  end

  // Next state and datapath capture.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    rsp_d   = rsp_q;
    unique case (state_q)
      IDLE: begin
        // cmd_ready is high in IDLE, so cmd_valid alone is the handshake.
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          write_d = cmd_write;
          wdata_d = cmd_wdata;
          if (cmd_addr[APB_ALIGN_BITS-1:0] != '0) begin
            // Misaligned: answer with an error without touching the bus.
            rsp_d   = '{rdata: '0, slverr: 1'b1, timeout: 1'b0};
            state_d = RESP;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // A same-cycle PREADY beats the timeout.
        if (PREADY) begin
          rsp_d.slverr  = PSLVERR;
          rsp_d.timeout = 1'b0;
          rsp_d.rdata   = (!write_q && !PSLVERR) ? PRDATA : '0;
          state_d       = RESP;
        end else if (to_expired) begin
          rsp_d   = '{rdata: '0, slverr: 1'b1, timeout: 1'b1};
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and APB strobes decoded from the registered state.
  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    unique case (state_q)
      IDLE:   cmd_ready = 1'b1;
      SETUP:  PSEL      = 1'b1;
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
      end
      RESP:   rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Bus fields hold the last command outside SETUP/ACCESS; the demux ignores them without PSEL.
  assign PADDR       = addr_q;
  assign PWRITE      = write_q;
  assign PWDATA      = wdata_q;
  assign rsp_rdata   = rsp_q.rdata;
  assign rsp_slverr  = rsp_q.slverr;
  assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Testbench for apb_master_bridge: directed cases plus random transfers against a transaction model.
// Latency: n/a.
// Backpressure: randomised rsp_ready hold-off and PREADY wait states.
module tb_apb_master_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic          cmd_write;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_slverr;
  logic          rsp_timeout;
  logic          PSEL;
  logic          PENABLE;
  logic [AW-1:0] PADDR;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic          PREADY;
  logic [DW-1:0] PRDATA;
  logic          PSLVERR;

  int checks   = 0;
  int failures = 0;

  apb_master_bridge #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_write   (cmd_write),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_slverr  (rsp_slverr),
    .rsp_timeout (rsp_timeout),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PADDR       (PADDR),
    .PWRITE      (PWRITE),
    .PWDATA      (PWDATA),
    .PREADY      (PREADY),
    .PRDATA      (PRDATA),
    .PSLVERR     (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All driving and sampling happens 1 time unit after the rising edge.
  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // One complete transfer. waits = PREADY-low ACCESS cycles before PREADY rises.
  // reset_at > 0 pulses PRESET on that ACCESS cycle instead of finishing.
  task automatic do_txn(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                        input int waits, input logic [DW-1:0] rdata, input logic err,
                        input int hold, input int reset_at);
    logic          mis;
    logic          exp_to;
    int            exp_acc;
    int            exp_lat;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            lat;
    int            setup_cnt;
    int            acc_cnt;

    // Transaction-level model of the expected outcome.
    mis = (addr[1:0] != 2'b00);
`ifdef APB_TIMEOUT_EN
    exp_to = !mis && (waits >= TO);
`else
    exp_to = 1'b0;
`endif
    exp_acc   = mis ? 0 : (exp_to ? TO : waits + 1);
    exp_lat   = mis ? 1 : 2 + exp_acc;
    exp_err   = mis || exp_to || err;
    exp_rdata = (mis || exp_to || wr || err) ? '0 : rdata;

    check_eq("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_write = wr;
    cmd_wdata = wdata;
    step();
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    lat       = 1;
    setup_cnt = 0;
    acc_cnt   = 0;

    for (int i = 0; i < 400 && !rsp_valid; i++) begin
      PREADY  = 1'b0;
      PRDATA  = $urandom;
      PSLVERR = $urandom_range(0, 1);
      check_eq("cmd_ready_busy", {63'd0, cmd_ready}, 64'd0);
      if (PSEL && !PENABLE) begin
        setup_cnt++;
        check_eq("setup_paddr", {32'd0, PADDR}, {32'd0, addr});
        check_eq("setup_pwrite", {63'd0, PWRITE}, {63'd0, wr});
      end
      if (PSEL && PENABLE) begin
        acc_cnt++;
        check_eq("access_paddr", {32'd0, PADDR}, {32'd0, addr});
        check_eq("access_pwrite", {63'd0, PWRITE}, {63'd0, wr});
        if (wr) check_eq("access_pwdata", {32'd0, PWDATA}, {32'd0, wdata});
        if (reset_at > 0 && acc_cnt == reset_at) begin
          PRESET = 1'b1;
          step();
          check_eq("rst_psel", {63'd0, PSEL}, 64'd0);
          check_eq("rst_penable", {63'd0, PENABLE}, 64'd0);
          check_eq("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
          PRESET = 1'b0;
          PREADY = 1'b0;
          step();
          check_eq("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
          check_eq("rst_rsp_valid2", {63'd0, rsp_valid}, 64'd0);
          return;
        end
        if (acc_cnt > waits) begin
          PREADY  = 1'b1;
          PRDATA  = rdata;
          PSLVERR = err;
        end
      end
      if (PENABLE && !PSEL) check_eq("penable_wo_psel", 64'd1, 64'd0);
      step();
      lat++;
    end
    PREADY = 1'b0;

    check_eq("rsp_wait", {63'd0, rsp_valid}, 64'd1);
    check_eq("latency", 64'(lat), 64'(exp_lat));
    check_eq("setup_cycles", 64'(setup_cnt), mis ? 64'd0 : 64'd1);
    check_eq("access_cycles", 64'(acc_cnt), 64'(exp_acc));

    for (int h = 0; h <= hold; h++) begin
      check_eq("rsp_valid_hold", {63'd0, rsp_valid}, 64'd1);
      check_eq("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, exp_rdata});
      check_eq("rsp_slverr", {63'd0, rsp_slverr}, {63'd0, exp_err});
      check_eq("rsp_timeout", {63'd0, rsp_timeout}, {63'd0, exp_to});
      check_eq("rsp_psel", {63'd0, PSEL}, 64'd0);
      check_eq("rsp_cmd_ready", {63'd0, cmd_ready}, 64'd0);
      if (h == hold) rsp_ready = 1'b1;
      step();
    end
    rsp_ready = 1'b0;
    check_eq("post_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check_eq("post_cmd_ready", {63'd0, cmd_ready}, 64'd1);
  endtask

  initial begin
    PRESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_write = 1'b0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    PREADY    = 1'b0;
    PRDATA    = '0;
    PSLVERR   = 1'b0;
    repeat (3) step();
    PRESET = 1'b0;

    check_eq("reset_psel", {63'd0, PSEL}, 64'd0);
    check_eq("reset_penable", {63'd0, PENABLE}, 64'd0);
    check_eq("reset_pwrite", {63'd0, PWRITE}, 64'd0);
    check_eq("reset_paddr", {32'd0, PADDR}, 64'd0);
    check_eq("reset_pwdata", {32'd0, PWDATA}, 64'd0);
    check_eq("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check_eq("reset_rsp_slverr", {63'd0, rsp_slverr}, 64'd0);
    check_eq("reset_rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
    check_eq("reset_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    check_eq("reset_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    // rsp_ready while nothing is pending must not disturb the idle bridge.
    rsp_ready = 1'b1;
    step();
    check_eq("idle_rsp_ready", {63'd0, rsp_valid}, 64'd0);
    rsp_ready = 1'b0;

    // Directed cases.
    do_txn(32'h0000_0040, 1'b1, 32'hDEAD_BEEF, 0, 32'h0BAD_0BAD, 1'b0, 0, 0);
    do_txn(32'h0000_0084, 1'b0, 32'h0, 3, 32'h1234_5678, 1'b0, 0, 0);
    do_txn(32'h0000_0088, 1'b0, 32'h0, 0, 32'hFFFF_FFFF, 1'b1, 5, 0);
    do_txn(32'h0000_0003, 1'b1, 32'hCAFE_F00D, 0, 32'h0, 1'b0, 1, 0);
    do_txn(32'h0000_0100, 1'b0, 32'h0, 20, 32'h5555_AAAA, 1'b0, 0, 2);
    do_txn(32'h0000_0104, 1'b0, 32'h0, 1, 32'hA5A5_5A5A, 1'b0, 0, 0);
`ifdef APB_TIMEOUT_EN
    do_txn(32'h0000_0200, 1'b0, 32'h0, 30, 32'h1111_2222, 1'b0, 0, 0);
    do_txn(32'h0000_0204, 1'b0, 32'h0, TO - 1, 32'h3333_4444, 1'b0, 0, 0);
`endif

    // Random transfers.
    for (int t = 0; t < 60; t++) begin
      logic [AW-1:0] a;
      int            w;
      a = $urandom;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      w = $urandom_range(0, 5);
`ifdef APB_TIMEOUT_EN
      if ($urandom_range(0, 5) == 0) w = $urandom_range(TO - 1, TO + 3);
`endif
      do_txn(a, 1'($urandom_range(0, 1)), $urandom, w, $urandom,
             ($urandom_range(0, 3) == 0), $urandom_range(0, 3), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
